decode_stage_q: RTL and testbench

- Second-generation instruction decoder with an elastic decode queue.
- Accepts 32-bit instruction words on a valid/ready handshake and resolves conditional jumps against the flags sampled at acceptance.
- Stores decoded control bundles (cu, alu, bus, io) in a DEPTH-entry FIFO.
- Adds over the first generation: logic/shift/signed-load ALU ops, loads/stores of several sizes, getc, an illegal-opcode trap, flush, halt lock-out, and a retired-instruction counter.

---
 rtl/decode_stage_q.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_decode_stage_q.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_q.sv
// Instruction decoder with an elastic queue of decoded control bundles.
// Resolves conditional jumps at acceptance and traps on undefined opcodes.
module decode_stage_q #(
    parameter int DATA_W        = 64,
    parameter int DEPTH         = 2,
    parameter int SIGNED_OFFSET = 0,
    parameter int COUNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        ir,
    input  logic               zf,
    input  logic               cf,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         cu_op,
    output logic [7:0]         exit_code,
    output logic [23:0]        jmp_offset,
    output logic [2:0]         alu_op,
    output logic               alu_a_sel,
    output logic [3:0]         s_reg,
    output logic [3:0]         b_reg,
    output logic [3:0]         a_reg,
    output logic [DATA_W-1:0]  a_imm,
    output logic [1:0]         bus_op,
    output logic [1:0]         bus_size,
    output logic [3:0]         data_reg,
    output logic [3:0]         addr_reg,
    output logic [16:0]        addr_offset,
    output logic [1:0]         io_op,
    output logic [7:0]         char_imm,
    output logic [3:0]         char_reg,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);

    localparam logic [1:0] CU_NOP  = 2'd0;
    localparam logic [1:0] CU_HALT = 2'd1;
    localparam logic [1:0] CU_JMP  = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SHL = 3'd5;
    localparam logic [2:0] ALU_SHR = 3'd6;

    localparam logic [1:0] BUS_FETCH = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_WORD   = 2'd1;
    localparam logic [1:0] SZ_QUAD   = 2'd3;

    localparam logic [1:0] IO_PUTC_REG = 2'd1;
    localparam logic [1:0] IO_PUTC_IMM = 2'd2;
    localparam logic [1:0] IO_GETC     = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_TRAP   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]        cu_op;
        logic [7:0]        exit_code;
        logic [23:0]       jmp_offset;
        logic [2:0]        alu_op;
        logic              alu_a_sel;
        logic [3:0]        s_reg;
        logic [3:0]        b_reg;
        logic [3:0]        a_reg;
        logic [DATA_W-1:0] a_imm;
        logic [1:0]        bus_op;
        logic [1:0]        bus_size;
        logic [3:0]        data_reg;
        logic [3:0]        addr_reg;
        logic [16:0]       addr_offset;
        logic [1:0]        io_op;
        logic [7:0]        char_imm;
        logic [3:0]        char_reg;
        logic              illegal;
    } entry_t;

    state_t             state_q, state_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    entry_t             last_q, last_d;

    entry_t     dec;
    entry_t     head;
    entry_t     shown;
    logic [7:0] op;
    logic       push;
    logic       pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign in_ready  = (fill_q < FILL_W'(DEPTH)) && (state_q == ST_RUN);
    assign out_valid = (fill_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Decode the incoming word into a control bundle, flags resolved now.
    always_comb begin
        op              = ir[31:24];
        dec             = '0;
        dec.exit_code   = ir[23:16];
        dec.jmp_offset  = ir[23:0];
        dec.s_reg       = ir[23:20];
        dec.b_reg       = ir[19:16];
        dec.a_reg       = ir[15:12];
        dec.a_imm       = DATA_W'(ir[15:0]);
        dec.data_reg    = ir[23:20];
        dec.addr_reg    = ir[19:16];
        dec.addr_offset = (SIGNED_OFFSET != 0) ? {ir[15], ir[15:0]}
                                               : {1'b0, ir[15:0]};
        dec.char_imm    = ir[23:16];
        dec.char_reg    = ir[23:20];
        case (op)
            8'h00: dec.cu_op = CU_NOP;
            8'h01: dec.cu_op = CU_HALT;
            8'h02: dec.cu_op = !zf ? CU_JMP : CU_NOP;
            8'h03: dec.cu_op = zf ? CU_JMP : CU_NOP;
            8'h04: dec.cu_op = CU_JMP;
            8'h05: dec.cu_op = cf ? CU_JMP : CU_NOP;
            8'h06: dec.cu_op = !cf ? CU_JMP : CU_NOP;
            8'h10, 8'h19: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_a_sel = 1'b1;
                dec.b_reg     = 4'd0;
                dec.a_reg     = 4'd0;
                dec.a_imm     = (op == 8'h19)
                              ? {{(DATA_W-20){ir[19]}}, ir[19:0]}
                              : DATA_W'(ir[19:0]);
            end
            8'h11: dec.alu_op = ALU_ADD;
            8'h13: dec.alu_op = ALU_SUB;
            8'h15: dec.alu_op = ALU_AND;
            8'h16: dec.alu_op = ALU_OR;
            8'h12: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_a_sel = 1'b1;
            end
            8'h14: begin
                dec.alu_op    = ALU_SUB;
                dec.alu_a_sel = 1'b1;
            end
            8'h17, 8'h18: begin
                dec.alu_op    = (op == 8'h17) ? ALU_SHL : ALU_SHR;
                dec.alu_a_sel = 1'b1;
                dec.a_imm     = DATA_W'(ir[5:0]);
            end
            8'h20: begin
                dec.bus_op   = BUS_FETCH;
                dec.bus_size = SZ_BYTE;
            end
            8'h21: begin
                dec.bus_op   = BUS_FETCH;
                dec.bus_size = SZ_WORD;
            end
            8'h22: begin
                dec.bus_op   = BUS_FETCH;
                dec.bus_size = SZ_QUAD;
            end
            8'h28: begin
                dec.bus_op   = BUS_STORE;
                dec.bus_size = SZ_BYTE;
            end
            8'h2A: begin
                dec.bus_op   = BUS_STORE;
                dec.bus_size = SZ_QUAD;
            end
            8'h30: dec.io_op = IO_PUTC_REG;
            8'h31: dec.io_op = IO_PUTC_IMM;
            8'h32: dec.io_op = IO_GETC;
            default: dec.illegal = 1'b1;
        endcase
    end

    // Queue bookkeeping; flush wins over both push and pop.
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        fill_d = fill_q;
        if (flush) begin
            wr_d   = '0;
            rd_d   = '0;
            fill_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = dec;
                wr_d        = next_ptr(wr_q);
            end
            if (pop) begin
                rd_d = next_ptr(rd_q);
            end
            fill_d = fill_q + FILL_W'(push) - FILL_W'(pop);
        end
    end

    // Run/trap/halt control: a trap waits for flush, halt waits for reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (push && dec.illegal) begin
                    state_d = ST_TRAP;
                end else if (push && (op == 8'h01)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_TRAP: begin
                if (flush) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Retired count advances on every kept accept, wrapping naturally.
    always_comb begin
        cnt_d = cnt_q + COUNT_W'(push);
    end

    // Present the head; with an empty queue hold fields and squash ops.
    always_comb begin
        head   = out_valid ? mem_q[rd_q] : last_q;
        last_d = head;
        shown  = head;
        if (!out_valid) begin
            shown.cu_op   = CU_NOP;
            shown.alu_op  = 3'd0;
            shown.bus_op  = 2'd0;
            shown.io_op   = 2'd0;
            shown.illegal = 1'b0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Entry storage needs no reset; validity lives in fill_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cu_op       = shown.cu_op;
    assign exit_code   = shown.exit_code;
    assign jmp_offset  = shown.jmp_offset;
    assign alu_op      = shown.alu_op;
    assign alu_a_sel   = shown.alu_a_sel;
    assign s_reg       = shown.s_reg;
    assign b_reg       = shown.b_reg;
    assign a_reg       = shown.a_reg;
    assign a_imm       = shown.a_imm;
    assign bus_op      = shown.bus_op;
    assign bus_size    = shown.bus_size;
    assign data_reg    = shown.data_reg;
    assign addr_reg    = shown.addr_reg;
    assign addr_offset = shown.addr_offset;
    assign io_op       = shown.io_op;
    assign char_imm    = shown.char_imm;
    assign char_reg    = shown.char_reg;
    assign illegal     = shown.illegal;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_decode_stage_q.sv
// Bench for decode_stage_q: scoreboard of expected bundles in accept order,
// plus per-scenario checks of ready, flush, trap, halt and counter.
module tb_decode_stage_q;

    typedef struct packed {
        logic [1:0]  cu;
        logic [7:0]  exit_code;
        logic [23:0] jmp;
        logic [2:0]  alu;
        logic        sel;
        logic [3:0]  s;
        logic [3:0]  b;
        logic [3:0]  a;
        logic [63:0] imm;
        logic [1:0]  bus;
        logic [1:0]  size;
        logic [3:0]  dreg;
        logic [3:0]  areg;
        logic [16:0] off;
        logic [1:0]  io;
        logic [7:0]  cimm;
        logic [3:0]  creg;
        logic        ill;
    } exp_t;

    localparam logic [7:0] ALU_OPS [8] = '{8'h11, 8'h13, 8'h15, 8'h16,
                                           8'h12, 8'h14, 8'h17, 8'h18};
    localparam logic [2:0] ALU_EXP [8] = '{3'd1, 3'd2, 3'd3, 3'd4,
                                           3'd1, 3'd2, 3'd5, 3'd6};
    localparam logic       ALU_SEL [8] = '{1'b0, 1'b0, 1'b0, 1'b0,
                                           1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [7:0] MIO_OPS [8] = '{8'h20, 8'h21, 8'h22, 8'h28,
                                           8'h2A, 8'h30, 8'h31, 8'h32};
    localparam logic [1:0] MIO_BUS [8] = '{2'd1, 2'd1, 2'd1, 2'd2,
                                           2'd2, 2'd0, 2'd0, 2'd0};
    localparam logic [1:0] MIO_SZ  [8] = '{2'd0, 2'd1, 2'd3, 2'd0,
                                           2'd3, 2'd0, 2'd0, 2'd0};
    localparam logic [1:0] MIO_IO  [8] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                           2'd0, 2'd1, 2'd2, 2'd3};
    localparam logic [7:0] J_OPS [7] = '{8'h03, 8'h03, 8'h04, 8'h05,
                                         8'h05, 8'h06, 8'h06};
    localparam logic       J_ZF  [7] = '{1'b1, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0};
    localparam logic       J_CF  [7] = '{1'b0, 1'b0, 1'b0, 1'b1,
                                         1'b0, 1'b0, 1'b1};
    localparam logic [1:0] J_CU  [7] = '{2'd2, 2'd0, 2'd2, 2'd2,
                                         2'd0, 2'd2, 2'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ir = '0;
    logic        zf = 1'b0;
    logic        cf = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  cu_op;
    logic [7:0]  exit_code;
    logic [23:0] jmp_offset;
    logic [2:0]  alu_op;
    logic        alu_a_sel;
    logic [3:0]  s_reg, b_reg, a_reg;
    logic [63:0] a_imm;
    logic [1:0]  bus_op, bus_size;
    logic [3:0]  data_reg, addr_reg;
    logic [16:0] addr_offset;
    logic [1:0]  io_op;
    logic [7:0]  char_imm;
    logic [3:0]  char_reg;
    logic        illegal;
    logic [31:0] instr_count;

    exp_t        got;
    exp_t        nxt;
    exp_t        sbq [$];
    logic [31:0] exp_cnt = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    decode_stage_q #(
        .DATA_W(64), .DEPTH(2), .SIGNED_OFFSET(1), .COUNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ir(ir), .zf(zf), .cf(cf), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .cu_op(cu_op), .exit_code(exit_code), .jmp_offset(jmp_offset),
        .alu_op(alu_op), .alu_a_sel(alu_a_sel),
        .s_reg(s_reg), .b_reg(b_reg), .a_reg(a_reg), .a_imm(a_imm),
        .bus_op(bus_op), .bus_size(bus_size),
        .data_reg(data_reg), .addr_reg(addr_reg), .addr_offset(addr_offset),
        .io_op(io_op), .char_imm(char_imm), .char_reg(char_reg),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign got = {cu_op, exit_code, jmp_offset, alu_op, alu_a_sel,
                  s_reg, b_reg, a_reg, a_imm, bus_op, bus_size,
                  data_reg, addr_reg, addr_offset, io_op,
                  char_imm, char_reg, illegal};

    function automatic exp_t base(input logic [31:0] w);
        exp_t e;
        e           = '0;
        e.exit_code = w[23:16];
        e.jmp       = w[23:0];
        e.s         = w[23:20];
        e.b         = w[19:16];
        e.a         = w[15:12];
        e.imm       = {48'h0, w[15:0]};
        e.dreg      = w[23:20];
        e.areg      = w[19:16];
        e.off       = {w[15], w[15:0]};
        e.cimm      = w[23:16];
        e.creg      = w[23:20];
        return e;
    endfunction

    // One clock: score the head against the queue, record any accept.
    task automatic tick();
        exp_t e;
        n_cmp++;
        if (instr_count !== exp_cnt) begin
            n_err++;
            $display("FAIL instr_count got %0d want %0d", instr_count, exp_cnt);
        end
        n_cmp++;
        if (out_valid !== (sbq.size() != 0)) begin
            n_err++;
            $display("FAIL out_valid got %b want %b", out_valid, sbq.size() != 0);
        end
        if (!out_valid) begin
            n_cmp++;
            if ({cu_op, alu_op, bus_op, io_op, illegal} !== 10'd0) begin
                n_err++;
                $display("FAIL idle_ops got %h want 0",
                         {cu_op, alu_op, bus_op, io_op, illegal});
            end
        end
        if (rst) begin
            sbq.delete();
            exp_cnt = '0;
        end else if (flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready && sbq.size() != 0) begin
                e = sbq.pop_front();
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL bundle got %h want %h", got, e);
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(nxt);
                exp_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_count got %0d want 0", instr_count);
        end
        n_cmp++;
        if ({cu_op, alu_op, bus_op, io_op, illegal} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_ops got %h want 0",
                     {cu_op, alu_op, bus_op, io_op, illegal});
        end
    endtask

    task automatic test_alu();
        logic [31:0] w;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        w = 32'h105ABCDE;
        ir = w;
        nxt = base(w);
        nxt.alu = 3'd1; nxt.sel = 1'b1; nxt.b = 4'd0; nxt.a = 4'd0;
        nxt.imm = 64'h0000_0000_000A_BCDE;
        tick();
        w = 32'h19080000;
        ir = w;
        nxt = base(w);
        nxt.alu = 3'd1; nxt.sel = 1'b1; nxt.b = 4'd0; nxt.a = 4'd0;
        nxt.imm = 64'hFFFF_FFFF_FFF8_0000;
        tick();
        for (int i = 0; i < 8; i++) begin
            w = {ALU_OPS[i], 24'h5C37B9};
            ir = w;
            nxt = base(w);
            nxt.alu = ALU_EXP[i];
            nxt.sel = ALU_SEL[i];
            if (i >= 6) nxt.imm = 64'h39;
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_mem_io();
        logic [31:0] w;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = {MIO_OPS[i], 24'h34FFFC};
            ir = w;
            nxt = base(w);
            nxt.bus  = MIO_BUS[i];
            nxt.size = MIO_SZ[i];
            nxt.io   = MIO_IO[i];
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ws [3];
        logic [31:0] c0;
        ws[0] = 32'h11123000;
        ws[1] = 32'h11456000;
        ws[2] = 32'h11789000;
        c0 = exp_cnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ir = ws[i];
            nxt = base(ws[i]);
            nxt.alu = 3'd1;
            if (i == 2) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_in_ready got %b want 0", in_ready);
                end
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (instr_count !== c0 + 32'd3) begin
            n_err++;
            $display("FAIL b2b_count got %0d want %0d", instr_count, c0 + 32'd3);
        end
        repeat (2) tick();
    endtask

    task automatic test_jump();
        logic [31:0] w;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        w = 32'h02000010;
        ir = w;
        zf = 1'b1; cf = 1'b0;
        nxt = base(w);
        tick();
        zf = 1'b0;
        nxt = base(w);
        nxt.cu = 2'd2;
        tick();
        for (int i = 0; i < 7; i++) begin
            w = {J_OPS[i], 24'h000100 + 24'(i)};
            ir = w;
            zf = J_ZF[i];
            cf = J_CF[i];
            nxt = base(w);
            nxt.cu = J_CU[i];
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        w = 32'h03000020;
        ir = w;
        zf = 1'b1; cf = 1'b0;
        nxt = base(w);
        nxt.cu = 2'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        zf = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_trap();
        logic [31:0] w;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        w = 32'hFF000000;
        ir = w;
        nxt = base(w);
        nxt.ill = 1'b1;
        tick();
        ir = 32'h11000000;
        nxt = base(32'h11000000);
        nxt.alu = 3'd1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL trap_in_ready got %b want 0", in_ready);
            end
            if (i == 1) out_ready = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL trap_flush got ready=%b valid=%b want ready=1 valid=0",
                     in_ready, out_valid);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w = 32'h15000000 + 32'(i);
            ir = w;
            nxt = base(w);
            nxt.alu = 3'd3;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_queue got %b want 0", out_valid);
        end
        tick();
    endtask

    task automatic test_halt();
        logic [31:0] w;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        w = 32'h01070000;
        ir = w;
        nxt = base(w);
        nxt.cu = 2'd1;
        tick();
        ir = 32'h11000000;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL halt_in_ready step %0d got %b want 0", i, in_ready);
            end
            flush = (i == 1);
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL halt_rst_ready got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_flush_accept();
        logic [31:0] w;
        logic [31:0] c0;
        c0 = exp_cnt;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        w = 32'h2034FFFC;
        ir = w;
        nxt = base(w);
        nxt.bus = 2'd1;
        nxt.off = 17'h1FFFC;
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (instr_count !== c0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_accept got cnt=%0d valid=%b want cnt=%0d valid=0",
                     instr_count, out_valid, c0);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ir = 32'h16000000 + 32'(i);
            nxt = base(ir);
            nxt.alu = 3'd4;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid got valid=%b cnt=%0d want valid=0 cnt=0",
                     out_valid, instr_count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_io();
        test_back_to_back();
        test_jump();
        test_trap();
        test_halt();
        test_flush_accept();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
